prod_accum: RTL and testbench

- Sequential accumulator directly downstream of the combinational 4x4 multiplier (`mult_4_4`); consumes its 8-bit product.
- Sums a frame of COUNT products and presents the frame total with valid/ready handshakes on both sides.
- Provides saturation and an overflow flag.
- Used for dot-product and MAC-style datapaths in the Adders area.

---
 rtl/adders_pkg.sv | 21 ++
 rtl/prod_accum_if.sv | 19 +
 rtl/sat_adder.sv | 17 +
 rtl/prod_accum.sv | 101 ++++++++++
 tb/tb_prod_accum.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/adders_pkg.sv
// Shared definitions for the adder-area blocks: product width, accumulator
// FSM state encodings and a generic saturating-add helper.
package adders_pkg;

  localparam int unsigned PROD_W = 8;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  // Returns {overflow, min(a + b, 2^w - 1)} for widths up to 32 bits.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] full;
    logic [32:0] max;
    full = {1'b0, a} + {1'b0, b};
    max  = (33'd1 << w) - 33'd1;
    if (full > max) return {1'b1, max[31:0]};
    return {1'b0, full[31:0]};
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / frame-sum-out handshake bundle for prod_accum.
interface prod_accum_if
  import adders_pkg::*;
#(
  parameter int unsigned PW = PROD_W,
  parameter int unsigned AW = 11
);
  logic [PW-1:0] P;
  logic          p_valid;
  logic          p_ready;
  logic [AW-1:0] S;
  logic          s_valid;
  logic          s_ready;
  logic          ovf;
  logic [7:0]    cnt;

  modport master (output P, p_valid, s_ready, input p_ready, S, s_valid, ovf, cnt);
  modport slave  (input P, p_valid, s_ready, output p_ready, S, s_valid, ovf, cnt);
endinterface

// File: rtl/sat_adder.sv
// Combinational unsigned saturating adder; clamps to all-ones on carry out.
module sat_adder #(
  parameter int unsigned AW = 11
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic [AW-1:0] sum_o,
  output logic          ovf_o
);
  logic [AW:0] full;

  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i};
    ovf_o = full[AW];
    sum_o = full[AW] ? {AW{1'b1}} : full[AW-1:0];
  end
endmodule

// File: rtl/prod_accum.sv
// Frame accumulator: sums COUNT products with saturation, then holds the total
// until the consumer takes it.
module prod_accum
  import adders_pkg::*;
#(
  parameter int unsigned PW    = PROD_W,
  parameter int unsigned AW    = 11,
  parameter int unsigned COUNT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  prod_accum_if.slave  bus
);
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] s_q, s_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ovf_int_q, ovf_int_d;
  logic          ovf_q, ovf_d;
  logic          s_valid_q, s_valid_d;

  logic [AW-1:0] p_ext;
  logic [AW-1:0] sum;
  logic          add_ovf;
  logic          accept;
  logic          last;

  assign p_ext  = AW'(bus.P);
  assign accept = bus.p_valid && (state_q == ACCUM);
  assign last   = (cnt_q == 8'(COUNT - 1));

  sat_adder #(.AW(AW)) u_add (
    .a_i   (acc_q),
    .b_i   (p_ext),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    ovf_d     = ovf_q;
    s_valid_d = s_valid_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last) begin
            s_d       = sum;
            ovf_d     = ovf_int_q | add_ovf;
            s_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_int_d = 1'b0;
            state_d   = HOLD;
          end else begin
            acc_d     = sum;
            cnt_d     = cnt_q + 8'd1;
            ovf_int_d = ovf_int_q | add_ovf;
          end
        end
      end
      HOLD: begin
        if (bus.s_ready) begin
          s_valid_d = 1'b0;
          state_d   = ACCUM;
        end
      end
    endcase
  end

  // clr aborts exactly like reset and overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      ovf_q     <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      ovf_q     <= ovf_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign bus.p_ready = (state_q == ACCUM);
  assign bus.S       = s_q;
  assign bus.s_valid = s_valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.cnt     = cnt_q;
endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench: three accumulators (AW=11, AW=10 with COUNT=8; COUNT=1)
// checked against a frame-sum reference model.
module tb_prod_accum;
  typedef struct {
    int s;
    bit o;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;

  prod_accum_if #(.AW(11)) ifa ();
  prod_accum_if #(.AW(10)) ifb ();
  prod_accum_if #(.AW(11)) ifc ();

  prod_accum #(.AW(11), .COUNT(8)) u_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa));
  prod_accum #(.AW(10), .COUNT(8)) u_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb));
  prod_accum #(.AW(11), .COUNT(1)) u_c (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifc));

  int total = 0;
  int bad   = 0;
  int fa[$];
  int fc[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int nacc_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: frame total is the plain sum, clamped to the result range.
  function automatic exp_t mk(input int sum, input int aw);
    int mx;
    mx   = (1 << aw) - 1;
    mk.s = (sum > mx) ? mx : sum;
    mk.o = (sum > mx);
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  always @(negedge clk) begin
    if (ifa.s_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious", 1, 0);
      else begin
        chk("a_S", ifa.S, qa[0].s);
        chk("a_ovf", ifa.ovf, qa[0].o);
        if (ifa.s_ready && !clr && rst_n) void'(qa.pop_front());
      end
    end
    if (ifb.s_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious", 1, 0);
      else begin
        chk("b_S", ifb.S, qb[0].s);
        chk("b_ovf", ifb.ovf, qb[0].o);
        if (ifb.s_ready && !clr && rst_n) void'(qb.pop_front());
      end
    end
    if (ifc.s_valid === 1'b1) begin
      if (qc.size() == 0) chk("c_spurious", 1, 0);
      else begin
        chk("c_S", ifc.S, qc[0].s);
        chk("c_ovf", ifc.ovf, qc[0].o);
        if (ifc.s_ready && !clr && rst_n) void'(qc.pop_front());
      end
    end
  end

  task automatic drop_all();
    fa.delete();
    fc.delete();
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drop_all();
    chk("rst_a_S", ifa.S, 0);
    chk("rst_a_svalid", ifa.s_valid, 0);
    chk("rst_a_ovf", ifa.ovf, 0);
    chk("rst_a_pready", ifa.p_ready, 1);
    chk("rst_a_cnt", ifa.cnt, 0);
    chk("rst_b_svalid", ifb.s_valid, 0);
    chk("rst_c_pready", ifc.p_ready, 1);
  endtask

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input bit pv, input int p, input bit sr,
                      input bit pvc, input int pc, input bit src, input bit cl);
    bit acc_ab;
    bit acc_c;
    ifa.p_valid = pv;  ifa.P = 8'(p);  ifa.s_ready = sr;
    ifb.p_valid = pv;  ifb.P = 8'(p);  ifb.s_ready = sr;
    ifc.p_valid = pvc; ifc.P = 8'(pc); ifc.s_ready = src;
    clr = cl;
    @(negedge clk);
    acc_ab = pv && (ifa.p_ready === 1'b1);
    acc_c  = pvc && (ifc.p_ready === 1'b1);
    chk("a_pready_vs_svalid", ifa.p_ready, !ifa.s_valid);
    chk("c_pready_vs_svalid", ifc.p_ready, !ifc.s_valid);
    if (ifa.p_ready === 1'b1) chk("a_cnt", ifa.cnt, fa.size());
    @(posedge clk);
    #1;
    if (cl) begin
      drop_all();
    end else begin
      if (acc_ab) begin
        fa.push_back(p);
        if (fa.size() == 8) begin
          qa.push_back(mk(qsum(fa), 11));
          qb.push_back(mk(qsum(fa), 10));
          fa.delete();
          chk("a_latency", ifa.s_valid, 1);
          chk("b_latency", ifb.s_valid, 1);
        end
      end
      if (acc_c) begin
        nacc_c++;
        fc.push_back(pc);
        qc.push_back(mk(qsum(fc), 11));
        fc.delete();
        chk("c_latency", ifc.s_valid, 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    ifa.p_valid = 1'b0; ifa.P = '0; ifa.s_ready = 1'b0;
    ifb.p_valid = 1'b0; ifb.P = '0; ifb.s_ready = 1'b0;
    ifc.p_valid = 1'b0; ifc.P = '0; ifc.s_ready = 1'b0;
    nacc_c = 0;
    do_reset();

    // Full-scale frame: 1800 fits in 11 bits, saturates in 10; then a small frame.
    repeat (8) step(1, 225, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (8) step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Bubbled frame then a five-cycle consumer stall.
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("a_back_to_accum", ifa.p_ready, 1);

    // Abort a partial frame with clr while p_valid is high.
    repeat (4) step(1, 10, 1, 0, 0, 0, 0);
    step(1, 10, 1, 0, 0, 0, 1);
    chk("a_cnt_after_clr", ifa.cnt, 0);
    repeat (8) step(1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Reset while holding a completed frame.
    repeat (8) step(1, 225, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("a_hold_S", ifa.S, 1800);
    do_reset();

    // COUNT=1: continuous traffic gives one frame every two cycles.
    nacc_c = 0;
    repeat (6) step(0, 0, 0, 1, 200, 1, 0);
    chk("c_period", nacc_c, 3);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 9) < 6,
           $urandom_range(0, 63) == 0);
    end

    repeat (4) step(0, 0, 1, 0, 0, 1, 0);
    chk("a_drained", qa.size(), 0);
    chk("b_drained", qb.size(), 0);
    chk("c_drained", qc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
